ac_ph_avg: RTL
==============

# ac_ph_avg

Post-processing stage directly downstream of the amplitude/phase cascade. It consumes one (phase, amplitude) result per frame and averages 2^NAVG_LOG2 consecutive results. Phase is averaged in a wrap-safe way. The averaged pair is presented on a valid/ready output register for the readout/interface logic.

## Interface
- NAVG_LOG2, default 3: log2 of the number of frame results per average (0..8; 0 = pass-through with 1-cycle latency).
- PH_WIDTH, default 32: phase width, signed binary angle (2^(PH_WIDTH-1) ≙ π).
- AC_WIDTH, default 32: amplitude width, unsigned.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- i_vld  in  1  one-cycle strobe; i_ph/i_ac hold a frame result. No backpressure toward upstream.
- i_ph  in  PH_WIDTH  signed phase difference.
- i_ac  in  AC_WIDTH  unsigned amplitude.
- i_clr  in  1  synchronous clear: discards the partial window and clears o_ovf.
- i_rdy  in  1  downstream ready.
- o_vld  out  1  averaged result valid.
- o_ph  out  PH_WIDTH  averaged phase.
- o_ac  out  AC_WIDTH  averaged amplitude.
- o_ovf  out  1  sticky flag: a completed average was dropped.

## Operation
- FSM states: IDLE, ACC, DONE.
- IDLE, on i_vld: ph_ref<=i_ph, dsum<=0, asum<=i_ac, cnt<=1.
  - Next state is ACC, or DONE if NAVG_LOG2=0.
- ACC, on i_vld:
  - d = i_ph − ph_ref, computed modulo 2^PH_WIDTH and interpreted as signed, so it lies in [−π, π).
  - dsum += sign-extended d; asum += i_ac; cnt++.
  - When the accepted sample is number 2^NAVG_LOG2, next state is DONE.
- Accumulator widths: dsum is signed PH_WIDTH+NAVG_LOG2; asum is unsigned AC_WIDTH+NAVG_LOG2. They cannot overflow.
- DONE (exactly 1 cycle):
  - res_ph = ph_ref + (dsum >>> NAVG_LOG2), arithmetic shift (floor toward −∞), truncated to PH_WIDTH, wraps naturally.
  - res_ac = asum >> NAVG_LOG2, floor.
  - If the output slot is free (!o_vld, or o_vld && i_rdy this cycle), load res into o_ph/o_ac and set o_vld=1.
  - Otherwise drop res, set o_ovf=1, and leave o_ph/o_ac unchanged.
- Leaving DONE: next state is IDLE. An i_vld in the DONE cycle is taken as the first sample of the next window (IDLE-entry actions, next state ACC).
- Output handshake:
  - A transfer occurs on a rising edge with o_vld && i_rdy.
  - While o_vld=1 && !i_rdy, o_ph/o_ac are stable.
  - If a transfer and a DONE-load happen on the same edge, the new result replaces the old and o_vld stays 1.
  - Otherwise a transfer clears o_vld.
- i_clr:
  - Takes priority over i_vld in the same cycle; that sample is dropped.
  - State goes to IDLE and o_ovf goes to 0.
  - A DONE-cycle load is suppressed.
  - The output register and o_vld are unaffected.

## Timing
- Reset (rstn=0, asynchronous):
  - o_vld=0, o_ph=0, o_ac=0, o_ovf=0.
  - State IDLE; cnt, dsum, asum, ph_ref all 0.
- Reset mid-window discards the partial window. The first i_vld after release starts a new window.
- Latency: the sample-2^NAVG_LOG2 capture edge moves the FSM to DONE. o_vld is high after the next edge, i.e. one cycle after the last sample is captured.
- Throughput: i_vld is accepted every cycle, including the DONE cycle. Back-to-back windows lose no samples.
- Combinational paths: none from inputs to outputs. o_vld/o_ph/o_ac/o_ovf are register outputs.

## Test plan
1. Basic average, default parameters:
   - Stimulus: 8 strobes with i_ph=1000 and i_ac=100..107, i_rdy=1.
   - Required: o_ph=1000, o_ac=103 (828>>3), o_vld high for 1 cycle, one cycle after the 8th strobe.
2. Phase wrap:
   - Stimulus: i_ph alternating 0x7FFF_F000 and 0x8000_1000 (first sample 0x7FFF_F000), 8 strobes.
   - Required: d alternates 0 and 0x2000, so o_ph=0x8000_0000, not ~0.
   - Negative floor check: a window with dsum=−3 gives o_ph=ph_ref−1.
3. Backpressure:
   - Stimulus: i_rdy=0, 16 strobes forming two windows.
   - Required: the first result is held stable; the second is dropped and o_ovf=1.
   - Then raising i_rdy transfers the first result and o_vld=0 the next cycle.
4. Clear mid-window:
   - Stimulus: 5 strobes (i_ac=500), i_clr for 1 cycle, then 8 strobes with i_ac=40.
   - Required: exactly one output, o_ac=40. o_ovf cleared.
   - Also: i_clr coincident with i_vld drops that sample.
5. Back-to-back throughput:
   - Stimulus: i_vld every cycle for 16 cycles, i_ac = sample index 0..15, i_rdy=1.
   - Required: two outputs, o_ac=3 then 11. Sample 8, arriving in the DONE cycle, starts window 2.
6. Reset mid-window:
   - Stimulus: 4 strobes, then rstn pulsed low asynchronously between edges.
   - Required: all outputs read 0 immediately.
   - After release, 8 strobes (i_ph=−8, i_ac=8) give o_ph=−8, o_ac=8.

Source files
------------

// File: rtl/ac_ph_avg.sv
// ---------------------------------------------------------------------------
// ac_ph_avg
// Averages 2^NAVG_LOG2 consecutive (phase, amplitude) frame results coming
// out of the amplitude/phase cascade. Phase is averaged relative to the first
// sample of each window, so windows that straddle the +/-pi boundary average
// correctly. The result sits in a valid/ready output register.
//
// Ports
//   clk    in   system clock, rising edge
//   rstn   in   asynchronous active-low reset
//   i_vld  in   one-cycle strobe, i_ph/i_ac hold a frame result
//   i_ph   in   signed binary-angle phase (2^(PH_WIDTH-1) = pi)
//   i_ac   in   unsigned amplitude
//   i_clr  in   synchronous clear of the partial window and o_ovf
//   i_rdy  in   downstream ready
//   o_vld  out  averaged result valid
//   o_ph   out  averaged phase
//   o_ac   out  averaged amplitude
//   o_ovf  out  sticky: a completed average was dropped (slot occupied)
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no window open, next i_vld becomes the phase reference
// S_ACC  | window open, accumulating phase offsets and amplitudes
// S_DONE | window complete, result is computed and offered this cycle
// ---------------------------------------------------------------------------
module ac_ph_avg #(
  parameter int NAVG_LOG2 = 3,
  parameter int PH_WIDTH  = 32,
  parameter int AC_WIDTH  = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_vld,
  input  logic [PH_WIDTH-1:0] i_ph,
  input  logic [AC_WIDTH-1:0] i_ac,
  input  logic                i_clr,
  input  logic                i_rdy,
  output logic                o_vld,
  output logic [PH_WIDTH-1:0] o_ph,
  output logic [AC_WIDTH-1:0] o_ac,
  output logic                o_ovf
);

  localparam int DW = PH_WIDTH + NAVG_LOG2;
  localparam int AW = AC_WIDTH + NAVG_LOG2;
  localparam int CW = NAVG_LOG2 + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << NAVG_LOG2) - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // A one-sample window completes on its first sample.
  localparam state_t FIRST_NEXT = (NAVG_LOG2 == 0) ? S_DONE : S_ACC;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [DW-1:0] dsum_q, dsum_d;
  logic [AW-1:0]        asum_q, asum_d;
  logic [PH_WIDTH-1:0]  ph_ref_q, ph_ref_d;
  logic                 o_vld_q, o_vld_d;
  logic [PH_WIDTH-1:0]  o_ph_q, o_ph_d;
  logic [AC_WIDTH-1:0]  o_ac_q, o_ac_d;
  logic                 o_ovf_q, o_ovf_d;

  logic signed [PH_WIDTH-1:0] d_ph;
  logic [PH_WIDTH-1:0]        res_ph;
  logic [AC_WIDTH-1:0]        res_ac;
  logic                       start;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dsum_d   = dsum_q;
    asum_d   = asum_q;
    ph_ref_d = ph_ref_q;
    o_vld_d  = o_vld_q;
    o_ph_d   = o_ph_q;
    o_ac_d   = o_ac_q;
    o_ovf_d  = o_ovf_q;
    start    = 1'b0;

    // Modulo difference, reinterpreted as signed: always the short way round.
    d_ph   = i_ph - ph_ref_q;
    // Arithmetic shift floors toward -inf; truncation then lets the sum wrap.
    res_ph = ph_ref_q + PH_WIDTH'(dsum_q >>> NAVG_LOG2);
    res_ac = AC_WIDTH'(asum_q >> NAVG_LOG2);

    if (o_vld_q && i_rdy) begin
      o_vld_d = 1'b0;
    end

    if (i_clr) begin
      state_d = S_IDLE;
      o_ovf_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          start = i_vld;
        end
        S_ACC: begin
          if (i_vld) begin
            dsum_d = dsum_q + DW'(d_ph);
            asum_d = asum_q + AW'(i_ac);
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          // Slot is free if empty or being drained on this same edge.
          if (!o_vld_q || i_rdy) begin
            o_vld_d = 1'b1;
            o_ph_d  = res_ph;
            o_ac_d  = res_ac;
          end else begin
            o_ovf_d = 1'b1;
          end
          state_d = S_IDLE;
          start   = i_vld;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    if (start) begin
      ph_ref_d = i_ph;
      dsum_d   = '0;
      asum_d   = AW'(i_ac);
      cnt_d    = CW'(1);
      state_d  = FIRST_NEXT;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dsum_q   <= '0;
      asum_q   <= '0;
      ph_ref_q <= '0;
      o_vld_q  <= 1'b0;
      o_ph_q   <= '0;
      o_ac_q   <= '0;
      o_ovf_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dsum_q   <= dsum_d;
      asum_q   <= asum_d;
      ph_ref_q <= ph_ref_d;
      o_vld_q  <= o_vld_d;
      o_ph_q   <= o_ph_d;
      o_ac_q   <= o_ac_d;
      o_ovf_q  <= o_ovf_d;
    end
  end

  assign o_vld = o_vld_q;
  assign o_ph  = o_ph_q;
  assign o_ac  = o_ac_q;
  assign o_ovf = o_ovf_q;

endmodule
